// File: rtl/avalon_reg_agent_if.sv
// Avalon-MM interface bundle; Agent modport faces the responder, Host the initiator.
// Combinational wiring only; flow control is carried by waitrequest.
// Host holds its command until it samples waitrequest low.
interface AVALON_IF #(
    parameter int ADDRESS_BITWIDTH = 4,
    parameter int DATA_BITWIDTH    = 32
);
    logic [ADDRESS_BITWIDTH-1:0]  address;
    logic [DATA_BITWIDTH/8-1:0]   byteenable;
    logic                         read;
    logic                         write;
    logic [DATA_BITWIDTH-1:0]     writedata;
    logic [DATA_BITWIDTH-1:0]     readdata;
    logic                         waitrequest;
    logic [1:0]                   response;

    modport Agent (
        input  address, byteenable, read, write, writedata,
        output readdata, waitrequest, response
    );

    modport Host (
        output address, byteenable, read, write, writedata,
        input  readdata, waitrequest, response
    );
endinterface

// File: rtl/avalon_reg_agent.sv
// Avalon-MM register bank responder; AVALON_REG_AGENT_DECODE_ERR_EN selects DECODEERROR for out-of-range hits.
// Latency: waitrequest high for 2+WAIT_STATES cycles, then one ACK cycle with registered response.
// Backpressure: waitrequest stalls the host; the command is not latched, so the host must hold it through ACK.
module avalon_reg_agent #(
    parameter int                       ADDRESS_BITWIDTH = 4,
    parameter int                       DATA_BITWIDTH    = 32,
    parameter int                       NUM_REGS         = 8,
    parameter int                       WAIT_STATES      = 1,
    parameter logic [DATA_BITWIDTH-1:0] RESET_VALUE      = '0
) (
    input  logic                               clk,
    input  logic                               rst_n,
    AVALON_IF.Agent                            avalon_if,
    output logic [NUM_REGS*DATA_BITWIDTH-1:0]  reg_out,
    output logic [NUM_REGS-1:0]                reg_wr_strobe
);
    localparam int          NUM_BYTES   = DATA_BITWIDTH / 8;
    localparam logic [3:0]  WS_INIT     = 4'(WAIT_STATES);
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
`ifdef AVALON_REG_AGENT_DECODE_ERR_EN
    localparam logic [1:0]  RESP_OOR    = 2'b11;
`else
    localparam logic [1:0]  RESP_OOR    = 2'b00;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t                    r_state, w_nxt_state;
    logic [3:0]                r_cnt, w_nxt_cnt;
    logic [DATA_BITWIDTH-1:0]  r_regs [NUM_REGS];
    logic [DATA_BITWIDTH-1:0]  r_readdata, w_nxt_readdata;
    logic [1:0]                r_resp, w_nxt_resp;
    logic [NUM_REGS-1:0]       r_strobe, w_nxt_strobe;
    logic                      r_waitreq;
    logic [NUM_REGS-1:0]       w_hit;
    logic                      w_in_range;
    logic                      w_req;
    logic [DATA_BITWIDTH-1:0]  w_rd_word;

    assign w_req = avalon_if.read | avalon_if.write;

    // One-hot address decode doubles as the read mux select and the write strobe.
    always_comb begin
        w_hit     = '0;
        w_rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (avalon_if.address == ADDRESS_BITWIDTH'(i)) begin
                w_hit[i]  = 1'b1;
                w_rd_word = r_regs[i];
            end
        end
        w_in_range = |w_hit;
    end

    always_comb begin
        w_nxt_state    = r_state;
        w_nxt_cnt      = r_cnt;
        w_nxt_readdata = '0;
        w_nxt_resp     = RESP_OKAY;
        w_nxt_strobe   = '0;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_nxt_state = S_WAIT;
                    w_nxt_cnt   = WS_INIT;
                end
            end
            S_WAIT: begin
                if (!w_req) begin
                    w_nxt_state = S_IDLE;
                end else if (r_cnt != 4'd0) begin
                    w_nxt_cnt = r_cnt - 4'd1;
                end else begin
                    w_nxt_state = S_ACK;
                    if (!w_in_range) begin
                        w_nxt_resp = RESP_OOR;
                    end else if (avalon_if.read) begin
                        // Read+write together resolves as a read with the write discarded.
                        w_nxt_readdata = w_rd_word;
                        w_nxt_resp     = avalon_if.write ? RESP_SLVERR : RESP_OKAY;
                    end else begin
                        w_nxt_strobe = w_hit;
                    end
                end
            end
            S_ACK:   w_nxt_state = S_IDLE;
            default: w_nxt_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_readdata <= '0;
            r_resp     <= RESP_OKAY;
            r_strobe   <= '0;
            r_waitreq  <= 1'b1;
        end else begin
            r_state    <= w_nxt_state;
            r_cnt      <= w_nxt_cnt;
            r_readdata <= w_nxt_readdata;
            r_resp     <= w_nxt_resp;
            r_strobe   <= w_nxt_strobe;
            r_waitreq  <= (w_nxt_state != S_ACK);
        end
    end

    // Commit at the end of ACK using the command the host is still holding.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= RESET_VALUE;
            end
        end else if (r_state == S_ACK) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (r_strobe[i]) begin
                    for (int b = 0; b < NUM_BYTES; b++) begin
                        if (avalon_if.byteenable[b]) begin
                            r_regs[i][b*8 +: 8] <= avalon_if.writedata[b*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    assign avalon_if.readdata    = r_readdata;
    assign avalon_if.response    = r_resp;
    assign avalon_if.waitrequest = r_waitreq;
    assign reg_wr_strobe         = r_strobe;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
        assign reg_out[g*DATA_BITWIDTH +: DATA_BITWIDTH] = r_regs[g];
    end
endmodule

// File: tb/tb_avalon_reg_agent.sv
// Scoreboard bench for avalon_reg_agent: stimulus pushes expected ACK contents, a monitor pops at each ACK.
module tb_avalon_reg_agent;
    localparam int          AW = 4;
    localparam int          DW = 32;
    localparam int          NR = 8;
    localparam int          WS = 1;
    localparam logic [31:0] RV = 32'hA5A5_0F0F;
`ifdef AVALON_REG_AGENT_DECODE_ERR_EN
    localparam logic [1:0]  OOR = 2'b11;
`else
    localparam logic [1:0]  OOR = 2'b00;
`endif

    typedef struct {
        logic [31:0] rd;
        logic [1:0]  resp;
        logic [7:0]  stb;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [NR*DW-1:0]   reg_out, reg_out0;
    logic [NR-1:0]      stb, stb0;
    logic [31:0]        model [NR];
    exp_t               exp_q [$];
    exp_t               mon_e;
    int                 n_vec = 0;
    int                 n_bad = 0;

    always #5 clk = ~clk;

    AVALON_IF #(.ADDRESS_BITWIDTH(AW), .DATA_BITWIDTH(DW)) av  ();
    AVALON_IF #(.ADDRESS_BITWIDTH(AW), .DATA_BITWIDTH(DW)) av0 ();

    avalon_reg_agent #(
        .ADDRESS_BITWIDTH(AW), .DATA_BITWIDTH(DW), .NUM_REGS(NR),
        .WAIT_STATES(WS), .RESET_VALUE(RV)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .avalon_if(av),
        .reg_out(reg_out), .reg_wr_strobe(stb)
    );

    avalon_reg_agent #(
        .ADDRESS_BITWIDTH(AW), .DATA_BITWIDTH(DW), .NUM_REGS(NR),
        .WAIT_STATES(0), .RESET_VALUE(RV)
    ) u_dut0 (
        .clk(clk), .rst_n(rst_n), .avalon_if(av0),
        .reg_out(reg_out0), .reg_wr_strobe(stb0)
    );

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    function automatic logic [255:0] model_vec();
        logic [255:0] v;
        v = '0;
        for (int i = 0; i < NR; i++) v[i*32 +: 32] = model[i];
        return v;
    endfunction

    // Reference behaviour: compute the ACK contents and the new register file, then drive the host side.
    task automatic xfer(input logic rd, input logic wr, input logic [3:0] a,
                        input logic [3:0] be, input logic [31:0] d);
        exp_t e;
        int   hi;
        e.rd = 32'h0; e.resp = 2'b00; e.stb = 8'h00;
        if (int'(a) >= NR) begin
            e.resp = OOR;
        end else if (rd) begin
            e.rd   = model[a];
            e.resp = wr ? 2'b10 : 2'b00;
        end else begin
            e.stb = 8'(1) << a;
            for (int b = 0; b < 4; b++)
                if (be[b]) model[a][b*8 +: 8] = d[b*8 +: 8];
        end
        exp_q.push_back(e);
        av.address = a; av.byteenable = be; av.writedata = d;
        av.read = rd; av.write = wr;
        hi = 0;
        @(negedge clk);
        while (av.waitrequest !== 1'b0 && hi < 40) begin
            hi++;
            @(negedge clk);
        end
        chk("wait_cycles", 256'(hi), 256'(2 + WS));
        @(posedge clk);
        #1;
        av.read = 1'b0; av.write = 1'b0;
        chk("reg_out", reg_out, model_vec());
    endtask

    task automatic xfer0(input logic rd, input logic wr, input logic [3:0] a, input logic [31:0] d,
                         output int hi, output logic [31:0] rdat, output logic [7:0] s);
        av0.address = a; av0.byteenable = 4'hF; av0.writedata = d;
        av0.read = rd; av0.write = wr;
        hi = 0;
        @(negedge clk);
        while (av0.waitrequest !== 1'b0 && hi < 40) begin
            hi++;
            @(negedge clk);
        end
        rdat = av0.readdata;
        s    = stb0;
        @(posedge clk);
        #1;
        av0.read = 1'b0; av0.write = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && av.waitrequest === 1'b0) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_ack: ack seen with no transfer pending, required none");
            end else begin
                mon_e = exp_q.pop_front();
                chk("readdata", 256'(av.readdata), 256'(mon_e.rd));
                chk("response", 256'(av.response), 256'(mon_e.resp));
                chk("strobe",   256'(stb),          256'(mon_e.stb));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0]  a, be;
        logic [31:0] d, rdat;
        logic [7:0]  s;
        logic        rd, wr;
        int          k, hi;

        av.address = '0; av.byteenable = '0; av.writedata = '0; av.read = 1'b0; av.write = 1'b0;
        av0.address = '0; av0.byteenable = '0; av0.writedata = '0; av0.read = 1'b0; av0.write = 1'b0;
        for (int i = 0; i < NR; i++) model[i] = RV;

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_waitrequest", 256'(av.waitrequest), 256'(1));
        chk("rst_response",    256'(av.response),    256'(0));
        chk("rst_readdata",    256'(av.readdata),    256'(0));
        chk("rst_strobe",      256'(stb),            256'(0));
        chk("rst_reg_out",     reg_out,              {NR{RV}});

        @(posedge clk); #1;
        xfer(1'b0, 1'b1, 4'd3, 4'hF, 32'hDEADBEEF);
        chk("reg3_value", 256'(reg_out[3*32 +: 32]), 256'(32'hDEADBEEF));
        xfer(1'b1, 1'b0, 4'd3, 4'h0, 32'h0);
        xfer(1'b0, 1'b1, 4'd2, 4'hF, 32'h11223344);
        xfer(1'b0, 1'b1, 4'd2, 4'b0101, 32'hAABBCCDD);
        chk("reg2_merge", 256'(reg_out[2*32 +: 32]), 256'(32'h11BB33DD));
        xfer(1'b1, 1'b0, 4'd2, 4'h0, 32'h0);
        xfer(1'b1, 1'b0, 4'd9, 4'h0, 32'h0);
        xfer(1'b0, 1'b1, 4'd9, 4'hF, 32'h0BAD0BAD);
        xfer(1'b0, 1'b1, 4'd1, 4'hF, 32'h5);
        xfer(1'b1, 1'b1, 4'd1, 4'hF, 32'hFFFF_FFFF);
        chk("reg1_after_rw", 256'(reg_out[1*32 +: 32]), 256'(32'h5));
        xfer(1'b0, 1'b1, 4'd4, 4'h0, 32'h87654321);

        // Reset pulse while the write to register 0 is still waiting.
        av.address = 4'd0; av.byteenable = 4'hF; av.writedata = 32'h12345678;
        av.read = 1'b0; av.write = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        av.write = 1'b0;
        for (int i = 0; i < NR; i++) model[i] = RV;
        repeat (4) @(negedge clk);
        chk("midrst_waitrequest", 256'(av.waitrequest), 256'(1));
        chk("midrst_reg0",        256'(reg_out[31:0]), 256'(RV));
        chk("midrst_reg_out",     reg_out,             model_vec());

        @(posedge clk); #1;
        for (int n = 0; n < 150; n++) begin
            a  = 4'($urandom_range(0, 11));
            k  = $urandom_range(0, 9);
            be = 4'($urandom);
            d  = $urandom;
            rd = (k >= 5);
            wr = (k < 5) || (k == 9 && int'(a) < NR);
            xfer(rd, wr, a, be, d);
        end

        xfer0(1'b0, 1'b1, 4'd5, 32'hCAFEF00D, hi, rdat, s);
        chk("ws0_wr_wait_cycles", 256'(hi), 256'(2));
        chk("ws0_wr_strobe",      256'(s),  256'(8'h20));
        chk("ws0_reg5",           256'(reg_out0[5*32 +: 32]), 256'(32'hCAFEF00D));
        xfer0(1'b1, 1'b0, 4'd5, 32'h0, hi, rdat, s);
        chk("ws0_rd_wait_cycles", 256'(hi),   256'(2));
        chk("ws0_readdata",       256'(rdat), 256'(32'hCAFEF00D));

        repeat (3) @(negedge clk);
        chk("ack_queue_empty", 256'(exp_q.size()), 256'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
